// File: rtl/encoder83_seq.sv
// rtl/encoder83_seq.sv - sequential 8-to-3 priority encoder with pending capture and valid/ready grant
module encoder83_seq #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] inp,
  input  logic       ready,
  output logic [2:0] code_out,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam logic [7:0] DEASSERTED = ACTIVE_LOW ? 8'hFF : 8'h00;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [7:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;
  logic [7:0] prev_q;

  logic [7:0] asserted, prev_asserted, rise, capture, clr;
  logic [2:0] sel, grant_idx;

  assign asserted      = ACTIVE_LOW ? ~inp : inp;
  assign prev_asserted = ACTIVE_LOW ? ~prev_q : prev_q;
  assign rise          = asserted & ~prev_asserted;
  assign capture       = enable ? rise : 8'h00;
  assign grant_idx     = 3'd7 - code_q;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    sel = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pending_q[k]) sel = 3'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    clr     = 8'h00;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (enable && (pending_q != 8'h00)) begin
          code_d  = 3'd7 - sel;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) begin
          clr     = 8'd1 << grant_idx;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    // A new rise on the bit being cleared re-sets it and is not an overflow.
    pending_d  = (pending_q & ~clr) | capture;
    overflow_d = overflow_q | (|(capture & pending_q & ~clr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= 3'd0;
      valid_q    <= 1'b0;
      pending_q  <= 8'h00;
      overflow_q <= 1'b0;
      prev_q     <= DEASSERTED;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      prev_q     <= inp;
    end
  end

  assign code_out = code_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_encoder83_seq.sv
// tb/tb_encoder83_seq.sv - directed self-checking bench for encoder83_seq
module tb_encoder83_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] inp;
  logic       ready;
  logic [2:0] code_out;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  encoder83_seq #(.ACTIVE_LOW(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .inp      (inp),
    .ready    (ready),
    .code_out (code_out),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; inp = 8'h00; ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {7'd0, valid}, 8'h00);
    chk("rst_pending", pending, 8'h00);
    chk("rst_overflow", {7'd0, overflow}, 8'h00);
    chk("rst_code", {5'd0, code_out}, 8'h00);
    rst = 1'b0; inp = 8'hFF;
    tick();
    chk("post_rst_pending", pending, 8'h00);
    chk("post_rst_valid", {7'd0, valid}, 8'h00);

    // single request on line 2
    inp = 8'hFB; ready = 1'b1;
    tick();
    chk("single_pending", pending, 8'h04);
    chk("single_valid0", {7'd0, valid}, 8'h00);
    tick();
    chk("single_valid1", {7'd0, valid}, 8'h01);
    chk("single_code", {5'd0, code_out}, 8'h05);
    tick();
    chk("single_done_valid", {7'd0, valid}, 8'h00);
    chk("single_done_pending", pending, 8'h00);

    // lines 7 and 0 together
    inp = 8'hFF; tick();
    inp = 8'h7E; tick();
    chk("dual_pending", pending, 8'h81);
    tick();
    chk("dual_code7", {5'd0, code_out}, 8'h00);
    chk("dual_valid7", {7'd0, valid}, 8'h01);
    tick();
    chk("dual_pending_mid", pending, 8'h01);
    chk("dual_valid_mid", {7'd0, valid}, 8'h00);
    tick();
    chk("dual_code0", {5'd0, code_out}, 8'h07);
    chk("dual_valid0", {7'd0, valid}, 8'h01);
    tick();
    chk("dual_end_pending", pending, 8'h00);
    chk("dual_end_valid", {7'd0, valid}, 8'h00);

    // hold a grant while a higher-priority line arrives
    ready = 1'b0; inp = 8'hFF; tick();
    inp = 8'hFB; tick();
    tick();
    chk("hold_code", {5'd0, code_out}, 8'h05);
    chk("hold_valid", {7'd0, valid}, 8'h01);
    inp = 8'h7B; tick();
    chk("hold_pending", pending, 8'h84);
    chk("hold_code_stable", {5'd0, code_out}, 8'h05);
    tick();
    chk("hold_code_stable2", {5'd0, code_out}, 8'h05);
    chk("hold_valid_stable", {7'd0, valid}, 8'h01);
    ready = 1'b1; tick();
    chk("hold_accept_pending", pending, 8'h80);
    chk("hold_accept_valid", {7'd0, valid}, 8'h00);
    tick();
    chk("hold_next_code", {5'd0, code_out}, 8'h00);
    chk("hold_next_valid", {7'd0, valid}, 8'h01);
    tick();
    chk("hold_end_pending", pending, 8'h00);
    ready = 1'b0;

    // overflow: line 2 re-asserted while pending
    inp = 8'hFF; tick();
    inp = 8'hFB; tick();
    chk("ovf_pre", {7'd0, overflow}, 8'h00);
    inp = 8'hFF; tick();
    inp = 8'hFB; tick();
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    chk("ovf_pending", pending, 8'h04);
    ready = 1'b1; tick();
    chk("ovf_sticky", {7'd0, overflow}, 8'h01);
    chk("ovf_drain_pending", pending, 8'h00);
    ready = 1'b0; inp = 8'hFF; rst = 1'b1; tick();
    chk("ovf_cleared", {7'd0, overflow}, 8'h00);
    rst = 1'b0;

    // line 3 re-asserted in the cycle its grant is accepted
    inp = 8'hF7; tick();
    chk("same_pending", pending, 8'h08);
    inp = 8'hFF; tick();
    chk("same_code", {5'd0, code_out}, 8'h04);
    inp = 8'hF7; ready = 1'b1; tick();
    chk("same_keep_pending", pending, 8'h08);
    chk("same_valid0", {7'd0, valid}, 8'h00);
    chk("same_no_ovf", {7'd0, overflow}, 8'h00);
    ready = 1'b0; tick();
    chk("same_regrant_code", {5'd0, code_out}, 8'h04);
    chk("same_regrant_valid", {7'd0, valid}, 8'h01);
    ready = 1'b1; tick();
    chk("same_end_pending", pending, 8'h00);
    ready = 1'b0;

    // disabled edge is consumed
    inp = 8'hFF; tick();
    enable = 1'b0; inp = 8'hDF; tick();
    chk("dis_pending", pending, 8'h00);
    tick();
    chk("dis_valid", {7'd0, valid}, 8'h00);
    enable = 1'b1; tick();
    chk("reen_pending", pending, 8'h00);
    tick();
    chk("reen_valid", {7'd0, valid}, 8'h00);
    chk("reen_pending2", pending, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
